// File: rtl/board_link_if.sv
// board_link_if
//   Bundles the Stage-side request/flag signals and the two inter-board
//   wires of the board link into one interface.
//   Modports:
//     master : the side that drives requests and the incoming wire
//              (Stage plus the peer line), observes flags and link_tx
//     slave  : the board_link block itself
//   Signals:
//     send_connect, send_start, send_game_finish  request levels/pulses
//     clear_rx                                    1-cycle clear of receive_* flags
//     link_rx                                     line from the peer, idles high
//     link_tx                                     line to the peer, idles high
//     receive_connect, receive_start,
//     receive_game_finish                         sticky receive flags
//     tx_busy                                     frame in flight or request pending
//     rx_error                                    1-cycle pulse on a corrupt frame
//     link_fail                                   sticky retry exhaustion flag
interface board_link_if;
   logic send_connect;
   logic send_start;
   logic send_game_finish;
   logic clear_rx;
   logic link_rx;
   logic link_tx;
   logic receive_connect;
   logic receive_start;
   logic receive_game_finish;
   logic tx_busy;
   logic rx_error;
   logic link_fail;

   modport master (
      output send_connect,
      output send_start,
      output send_game_finish,
      output clear_rx,
      output link_rx,
      input  link_tx,
      input  receive_connect,
      input  receive_start,
      input  receive_game_finish,
      input  tx_busy,
      input  rx_error,
      input  link_fail
   );

   modport slave (
      input  send_connect,
      input  send_start,
      input  send_game_finish,
      input  clear_rx,
      input  link_rx,
      output link_tx,
      output receive_connect,
      output receive_start,
      output receive_game_finish,
      output tx_busy,
      output rx_error,
      output link_fail
   );
endinterface

// File: rtl/board_link.sv
// board_link
//   Single-wire serial link between the two game boards. Requests from the
//   Stage FSM (send_connect / send_start / send_game_finish) become 5-bit
//   frames on link_tx; frames arriving on link_rx set the sticky
//   receive_* flags for Stage.
//   Frame: start=0, c0, c1, parity=c0^c1, stop=1, each BIT_CYCLES clocks,
//   LSB first. Codes: 00 ACK, 01 CONNECT, 10 START, 11 FINISH.
//   Ports:
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    board_link_if.slave carrying every request, flag and line
//   Parameters:
//     BIT_CYCLES   clocks per bit (>= 4)
//     ACK_TIMEOUT  clocks to wait for an ACK (only with LINK_ACK_EN)
//     MAX_RETRY    retransmissions before link_fail (only with LINK_ACK_EN)
//   Build option:
//     LINK_ACK_EN  when defined, non-ACK frames are acknowledged by the peer
//                  and retransmitted on timeout; otherwise frames are
//                  fire-and-forget, received ACK codes are ignored and
//                  link_fail is tied low.
module board_link #(
   parameter int BIT_CYCLES  = 10000
`ifdef LINK_ACK_EN
   ,
   parameter int ACK_TIMEOUT = 200000,
   parameter int MAX_RETRY   = 3
`endif
) (
   input logic         clk,
   input logic         reset,
   board_link_if.slave bus
);

   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] CYC_HALF = CW'(BIT_CYCLES / 2 - 1);

   localparam logic [1:0] CODE_ACK     = 2'd0;
   localparam logic [1:0] CODE_CONNECT = 2'd1;
   localparam logic [1:0] CODE_START   = 2'd2;
   localparam logic [1:0] CODE_FINISH  = 2'd3;

`ifdef LINK_ACK_EN
   localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
   localparam logic [TW-1:0] TMR_LAST = TW'(ACK_TIMEOUT - 1);
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
   localparam bit ACK_ACCEPTED = 1'b1;
`else
   localparam bit ACK_ACCEPTED = 1'b0;
`endif

   typedef enum logic [1:0] {TX_IDLE, TX_BITS, TX_WAIT_ACK} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

   // Pending/edge vectors are indexed by message code, so index 0 is ACK.
   logic [3:1]    send_now;
   logic [3:1]    send_q;
   logic [3:0]    pending;
   logic [3:0]    pend_set;
   logic [3:0]    done_mask;
   logic [3:0]    pend_avail;
   logic [1:0]    sel_idx;
   logic          sel_valid;
   logic          frame_end;
   logic          msg_done;
   logic          load_frame;

   tx_state_t     tx_state;
   logic [1:0]    cur_idx;
   logic [CW-1:0] tx_cyc;
   logic [2:0]    tx_bit;
   logic [3:0]    tx_shift;
   logic          link_tx_q;

   logic          rx_meta;
   logic          rx_sync;
   logic          rx_prev;
   rx_state_t     rx_state;
   logic [CW-1:0] rx_cyc;
   logic [1:0]    rx_idx;
   logic [2:0]    rx_bits;
   logic          rx_good_p;
   logic [1:0]    rx_code_p;
   logic          rx_error_q;
   logic [3:1]    rx_flags;
   logic [3:1]    flag_set;

`ifdef LINK_ACK_EN
   logic [TW-1:0] ack_timer;
   logic [RW-1:0] retry_cnt;
   logic          link_fail_q;
   logic          ack_rx;
   logic          ack_timeout;
   logic          fail_now;
   logic          retry_now;
`endif

   // The four bits that follow the start bit, in transmit order from bit 0.
   function automatic logic [3:0] frame_tail(input logic [1:0] code);
      return {1'b1, code[0] ^ code[1], code[1], code[0]};
   endfunction

   assign send_now = {bus.send_game_finish, bus.send_start, bus.send_connect};

   // Request capture, message completion and next-frame selection. Selection
   // only looks at already-registered pending bits, which is what gives the
   // two-edge request-to-start-bit latency; it also allows the next frame to
   // be loaded in the very cycle the previous stop bit ends.
   always_comb begin
      pend_set  = {send_now & ~send_q, 1'b0};
      flag_set  = '0;
      if (rx_good_p) begin
         case (rx_code_p)
            CODE_CONNECT: flag_set[1] = 1'b1;
            CODE_START:   flag_set[2] = 1'b1;
            CODE_FINISH:  flag_set[3] = 1'b1;
            default:      ;
         endcase
      end
      frame_end = (tx_state == TX_BITS) && (tx_cyc == CYC_LAST) && (tx_bit == 3'd4);
`ifdef LINK_ACK_EN
      ack_rx      = rx_good_p && (rx_code_p == CODE_ACK);
      if (rx_good_p && (rx_code_p != CODE_ACK)) begin
         pend_set[0] = 1'b1;
      end
      ack_timeout = (tx_state == TX_WAIT_ACK) && !ack_rx && (ack_timer == TMR_LAST);
      fail_now    = ack_timeout && (retry_cnt == RETRY_MAX);
      retry_now   = ack_timeout && (retry_cnt != RETRY_MAX);
      msg_done    = (frame_end && (cur_idx == CODE_ACK)) ||
                    ((tx_state == TX_WAIT_ACK) && ack_rx) || fail_now;
`else
      msg_done    = frame_end;
`endif
      done_mask  = msg_done ? (4'b0001 << cur_idx) : 4'b0000;
      pend_avail = pending & ~done_mask;
      sel_valid  = |pend_avail;
      if (pend_avail[0]) begin
         sel_idx = CODE_ACK;
      end else if (pend_avail[1]) begin
         sel_idx = CODE_CONNECT;
      end else if (pend_avail[2]) begin
         sel_idx = CODE_START;
      end else begin
         sel_idx = CODE_FINISH;
      end
      load_frame = sel_valid && ((tx_state == TX_IDLE) || msg_done);
   end

   // Transmit FSM. A pending bit stays set until its message completes, so a
   // repeated request while the frame is still on the wire is absorbed.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state    <= TX_IDLE;
         send_q      <= '0;
         pending     <= '0;
         cur_idx     <= '0;
         tx_cyc      <= '0;
         tx_bit      <= '0;
         tx_shift    <= '1;
         link_tx_q   <= 1'b1;
`ifdef LINK_ACK_EN
         ack_timer   <= '0;
         retry_cnt   <= '0;
         link_fail_q <= 1'b0;
`endif
      end else begin
         send_q  <= send_now;
         pending <= (pending & ~done_mask) | pend_set;
`ifdef LINK_ACK_EN
         if (fail_now) begin
            link_fail_q <= 1'b1;
         end
`endif
         if (load_frame) begin
            tx_state  <= TX_BITS;
            cur_idx   <= sel_idx;
            tx_cyc    <= '0;
            tx_bit    <= '0;
            tx_shift  <= frame_tail(sel_idx);
            link_tx_q <= 1'b0;
`ifdef LINK_ACK_EN
            retry_cnt <= '0;
`endif
         end else begin
            case (tx_state)
               TX_BITS: begin
                  if (tx_cyc == CYC_LAST) begin
                     tx_cyc <= '0;
                     if (tx_bit == 3'd4) begin
`ifdef LINK_ACK_EN
                        if (cur_idx == CODE_ACK) begin
                           tx_state <= TX_IDLE;
                        end else begin
                           tx_state  <= TX_WAIT_ACK;
                           ack_timer <= '0;
                        end
`else
                        tx_state <= TX_IDLE;
`endif
                     end else begin
                        link_tx_q <= tx_shift[0];
                        tx_shift  <= {1'b1, tx_shift[3:1]};
                        tx_bit    <= tx_bit + 3'd1;
                     end
                  end else begin
                     tx_cyc <= tx_cyc + 1'b1;
                  end
               end
`ifdef LINK_ACK_EN
               TX_WAIT_ACK: begin
                  if (msg_done) begin
                     tx_state <= TX_IDLE;
                  end else if (retry_now) begin
                     tx_state  <= TX_BITS;
                     tx_cyc    <= '0;
                     tx_bit    <= '0;
                     tx_shift  <= frame_tail(cur_idx);
                     link_tx_q <= 1'b0;
                     retry_cnt <= retry_cnt + 1'b1;
                  end else begin
                     ack_timer <= ack_timer + 1'b1;
                  end
               end
`endif
               default: tx_state <= TX_IDLE;
            endcase
         end
      end
   end

   // link_rx is asynchronous to clk; nothing downstream sees it before
   // two flops. rx_prev gives the falling-edge detector its history.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= bus.link_rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
      end
   end

   // Receive FSM. The start bit is re-checked half a bit after the falling
   // edge so a short glitch is dropped silently; later bits are sampled one
   // full bit apart from there. The verdict is registered at the stop sample
   // and acted upon (flag set or error pulse) one cycle later.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_state   <= RX_IDLE;
         rx_cyc     <= '0;
         rx_idx     <= '0;
         rx_bits    <= '0;
         rx_good_p  <= 1'b0;
         rx_code_p  <= '0;
         rx_error_q <= 1'b0;
      end else begin
         rx_good_p  <= 1'b0;
         rx_error_q <= 1'b0;
         case (rx_state)
            RX_IDLE: begin
               if (rx_prev && !rx_sync) begin
                  rx_state <= RX_START;
                  rx_cyc   <= '0;
               end
            end
            RX_START: begin
               if (rx_cyc == CYC_HALF) begin
                  rx_cyc   <= '0;
                  rx_idx   <= '0;
                  rx_state <= rx_sync ? RX_IDLE : RX_DATA;
               end else begin
                  rx_cyc <= rx_cyc + 1'b1;
               end
            end
            RX_DATA: begin
               if (rx_cyc == CYC_LAST) begin
                  rx_cyc          <= '0;
                  rx_bits[rx_idx] <= rx_sync;
                  if (rx_idx == 2'd2) begin
                     rx_state <= RX_STOP;
                  end else begin
                     rx_idx <= rx_idx + 2'd1;
                  end
               end else begin
                  rx_cyc <= rx_cyc + 1'b1;
               end
            end
            RX_STOP: begin
               if (rx_cyc == CYC_LAST) begin
                  rx_cyc    <= '0;
                  rx_state  <= RX_IDLE;
                  rx_code_p <= rx_bits[1:0];
                  if (rx_sync && (rx_bits[2] == (rx_bits[0] ^ rx_bits[1]))) begin
                     rx_good_p <= ACK_ACCEPTED || (rx_bits[1:0] != CODE_ACK);
                  end else begin
                     rx_error_q <= 1'b1;
                  end
               end else begin
                  rx_cyc <= rx_cyc + 1'b1;
               end
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // Sticky receive flags; a set in the same cycle as clear_rx survives.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_flags <= '0;
      end else begin
         rx_flags <= (rx_flags & ~{3{bus.clear_rx}}) | flag_set;
      end
   end

   assign bus.link_tx             = link_tx_q;
   assign bus.receive_connect     = rx_flags[1];
   assign bus.receive_start       = rx_flags[2];
   assign bus.receive_game_finish = rx_flags[3];
   assign bus.tx_busy             = (tx_state != TX_IDLE) || (|pending);
   assign bus.rx_error            = rx_error_q;
`ifdef LINK_ACK_EN
   assign bus.link_fail           = link_fail_q;
`else
   assign bus.link_fail           = 1'b0;
`endif

endmodule

// File: tb/tb_board_link.sv
// tb_board_link
//   Directed bench for board_link with BIT_CYCLES=4 (ACK_TIMEOUT=64,
//   MAX_RETRY=2 when LINK_ACK_EN is defined). link_rx is either looped back
//   from link_tx or driven from rx_drive.
module tb_board_link;

   logic clk;
   logic reset;
   logic loopback;
   logic rx_drive;
   int   total;
   int   bad;
   int   err_seen;
   int   tx_falls;
   logic tx_prev;

   board_link_if bus ();

   assign bus.link_rx = loopback ? bus.link_tx : rx_drive;

   board_link #(
      .BIT_CYCLES(4)
`ifdef LINK_ACK_EN
      ,
      .ACK_TIMEOUT(64),
      .MAX_RETRY(2)
`endif
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Observed-event counters: rx_error pulses and link_tx falling edges.
   always @(negedge clk) begin
      if (bus.rx_error === 1'b1) err_seen++;
      if (tx_prev === 1'b1 && bus.link_tx === 1'b0) tx_falls++;
      tx_prev = bus.link_tx;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_clear();
      bus.clear_rx = 1'b1;
      tick(1);
      bus.clear_rx = 1'b0;
   endtask

   task automatic drive_rx_frame(input logic [4:0] bits);
      for (int b = 0; b < 5; b++) begin
         rx_drive = bits[b];
         tick(4);
      end
      rx_drive = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(3);
      total++;
      if (bus.link_tx !== 1'b1) begin bad++; $display("[TB] FAIL reset_link_tx: got %b expected 1", bus.link_tx); end
      total++;
      if ({bus.receive_connect, bus.receive_start, bus.receive_game_finish} !== 3'b000) begin
         bad++; $display("[TB] FAIL reset_flags: got %b expected 000",
                         {bus.receive_connect, bus.receive_start, bus.receive_game_finish});
      end
      total++;
      if ({bus.tx_busy, bus.rx_error, bus.link_fail} !== 3'b000) begin
         bad++; $display("[TB] FAIL reset_status: got %b expected 000", {bus.tx_busy, bus.rx_error, bus.link_fail});
      end
      reset = 1'b0;
      tick(3);
   endtask

   task automatic test_single_start();
      logic [4:0] pat = 5'b11100;
      loopback = 1'b0;
      bus.send_start = 1'b1;
      tick(1);
      total++;
      if (bus.link_tx !== 1'b1 || bus.tx_busy !== 1'b1) begin
         bad++; $display("[TB] FAIL start_latency: got tx=%b busy=%b expected tx=1 busy=1", bus.link_tx, bus.tx_busy);
      end
      for (int i = 0; i < 20; i++) begin
         tick(1);
         total++;
         if (bus.link_tx !== pat[i/4] || bus.tx_busy !== 1'b1) begin
            bad++; $display("[TB] FAIL start_frame cycle %0d: got tx=%b busy=%b expected tx=%b busy=1",
                            i, bus.link_tx, bus.tx_busy, pat[i/4]);
         end
      end
      bus.send_start = 1'b0;
      tick(1);
      total++;
      if (bus.link_tx !== 1'b1 || bus.tx_busy !== 1'b0) begin
         bad++; $display("[TB] FAIL start_after: got tx=%b busy=%b expected tx=1 busy=0", bus.link_tx, bus.tx_busy);
      end
      tick(4);
   endtask

   task automatic test_absorb();
      int falls0;
      falls0 = tx_falls;
      bus.send_start = 1'b1;
      tick(6);
      bus.send_start = 1'b0;
      tick(2);
      bus.send_start = 1'b1;
      tick(15);
      total++;
      if (bus.link_tx !== 1'b1 || bus.tx_busy !== 1'b0) begin
         bad++; $display("[TB] FAIL absorb_idle: got tx=%b busy=%b expected tx=1 busy=0", bus.link_tx, bus.tx_busy);
      end
      tick(17);
      total++;
      if (tx_falls - falls0 !== 1) begin
         bad++; $display("[TB] FAIL absorb_frames: got %0d expected 1", tx_falls - falls0);
      end
      bus.send_start = 1'b0;
      tick(4);
   endtask

   task automatic test_loopback_connect();
      loopback = 1'b1;
      bus.send_connect = 1'b1;
      tick(22);
      bus.send_connect = 1'b0;
      total++;
      if (bus.receive_connect !== 1'b0 || bus.link_tx !== 1'b1) begin
         bad++; $display("[TB] FAIL loop_early: got flag=%b tx=%b expected flag=0 tx=1", bus.receive_connect, bus.link_tx);
      end
      tick(4);
      total++;
      if (bus.receive_connect !== 1'b1) begin bad++; $display("[TB] FAIL loop_flag: got %b expected 1", bus.receive_connect); end
      tick(20);
      total++;
      if ({bus.receive_connect, bus.receive_start, bus.receive_game_finish} !== 3'b100) begin
         bad++; $display("[TB] FAIL loop_sticky: got %b expected 100",
                         {bus.receive_connect, bus.receive_start, bus.receive_game_finish});
      end
      pulse_clear();
      total++;
      if (bus.receive_connect !== 1'b0) begin bad++; $display("[TB] FAIL loop_clear: got %b expected 0", bus.receive_connect); end
      loopback = 1'b0;
      tick(2);
   endtask

   task automatic test_back_to_back();
      logic [4:0] pc = 5'b11010;
      logic [4:0] pf = 5'b10110;
      logic       exp;
      loopback = 1'b1;
      bus.send_connect = 1'b1;
      bus.send_game_finish = 1'b1;
      tick(1);
      for (int i = 0; i < 40; i++) begin
         tick(1);
         exp = (i < 20) ? pc[i/4] : pf[(i-20)/4];
         total++;
         if (bus.link_tx !== exp || bus.tx_busy !== 1'b1) begin
            bad++; $display("[TB] FAIL b2b_frame cycle %0d: got tx=%b busy=%b expected tx=%b busy=1",
                            i, bus.link_tx, bus.tx_busy, exp);
         end
      end
      bus.send_connect = 1'b0;
      bus.send_game_finish = 1'b0;
      tick(1);
      total++;
      if (bus.link_tx !== 1'b1 || bus.tx_busy !== 1'b0) begin
         bad++; $display("[TB] FAIL b2b_after: got tx=%b busy=%b expected tx=1 busy=0", bus.link_tx, bus.tx_busy);
      end
      tick(6);
      total++;
      if ({bus.receive_connect, bus.receive_start, bus.receive_game_finish} !== 3'b101) begin
         bad++; $display("[TB] FAIL b2b_flags: got %b expected 101",
                         {bus.receive_connect, bus.receive_start, bus.receive_game_finish});
      end
      loopback = 1'b0;
      tick(2);
   endtask

   task automatic test_rx_frames();
      int errs0;
      pulse_clear();
      errs0 = err_seen;
      drive_rx_frame(5'b11100);
      tick(10);
      total++;
      if ({bus.receive_connect, bus.receive_start, bus.receive_game_finish} !== 3'b010) begin
         bad++; $display("[TB] FAIL rx_start_flags: got %b expected 010",
                         {bus.receive_connect, bus.receive_start, bus.receive_game_finish});
      end
      drive_rx_frame(5'b10000);
      tick(10);
      total++;
      if ({bus.receive_connect, bus.receive_start, bus.receive_game_finish} !== 3'b010) begin
         bad++; $display("[TB] FAIL rx_ack_ignored: got %b expected 010",
                         {bus.receive_connect, bus.receive_start, bus.receive_game_finish});
      end
      total++;
      if (err_seen - errs0 !== 0) begin bad++; $display("[TB] FAIL rx_good_errors: got %0d expected 0", err_seen - errs0); end
   endtask

   task automatic test_bad_parity();
      int errs0;
      pulse_clear();
      errs0 = err_seen;
      drive_rx_frame(5'b10010);
      tick(12);
      total++;
      if (err_seen - errs0 !== 1) begin bad++; $display("[TB] FAIL parity_error_pulses: got %0d expected 1", err_seen - errs0); end
      total++;
      if ({bus.receive_connect, bus.receive_start, bus.receive_game_finish} !== 3'b000) begin
         bad++; $display("[TB] FAIL parity_flags: got %b expected 000",
                         {bus.receive_connect, bus.receive_start, bus.receive_game_finish});
      end
   endtask

   task automatic test_glitch();
      int errs0;
      pulse_clear();
      errs0 = err_seen;
      rx_drive = 1'b0;
      tick(1);
      rx_drive = 1'b1;
      tick(20);
      total++;
      if (err_seen - errs0 !== 0) begin bad++; $display("[TB] FAIL glitch_error: got %0d expected 0", err_seen - errs0); end
      total++;
      if ({bus.receive_connect, bus.receive_start, bus.receive_game_finish} !== 3'b000) begin
         bad++; $display("[TB] FAIL glitch_flags: got %b expected 000",
                         {bus.receive_connect, bus.receive_start, bus.receive_game_finish});
      end
      drive_rx_frame(5'b11010);
      tick(10);
      total++;
      if (bus.receive_connect !== 1'b1) begin bad++; $display("[TB] FAIL glitch_recover: got %b expected 1", bus.receive_connect); end
   endtask

   task automatic test_reset_mid_frame();
      bus.send_connect = 1'b1;
      tick(11);
      total++;
      if (bus.link_tx !== 1'b0) begin bad++; $display("[TB] FAIL midreset_before: got %b expected 0", bus.link_tx); end
      reset = 1'b1;
      #1;
      total++;
      if (bus.link_tx !== 1'b1 || bus.tx_busy !== 1'b0) begin
         bad++; $display("[TB] FAIL midreset_tx: got tx=%b busy=%b expected tx=1 busy=0", bus.link_tx, bus.tx_busy);
      end
      total++;
      if ({bus.receive_connect, bus.receive_start, bus.receive_game_finish} !== 3'b000) begin
         bad++; $display("[TB] FAIL midreset_flags: got %b expected 000",
                         {bus.receive_connect, bus.receive_start, bus.receive_game_finish});
      end
      bus.send_connect = 1'b0;
      tick(2);
      reset = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick(1);
         total++;
         if (bus.link_tx !== 1'b1 || bus.tx_busy !== 1'b0) begin
            bad++; $display("[TB] FAIL midreset_after cycle %0d: got tx=%b busy=%b expected tx=1 busy=0",
                            i, bus.link_tx, bus.tx_busy);
         end
      end
   endtask

`ifdef LINK_ACK_EN
   task automatic test_link_fail();
      int falls0;
      falls0 = tx_falls;
      bus.send_start = 1'b1;
      tick(200);
      total++;
      if (bus.link_fail !== 1'b0) begin bad++; $display("[TB] FAIL fail_early: got %b expected 0", bus.link_fail); end
      tick(60);
      total++;
      if (bus.link_fail !== 1'b1 || bus.tx_busy !== 1'b0) begin
         bad++; $display("[TB] FAIL fail_flag: got fail=%b busy=%b expected fail=1 busy=0", bus.link_fail, bus.tx_busy);
      end
      total++;
      if (tx_falls - falls0 !== 3) begin bad++; $display("[TB] FAIL fail_frames: got %0d expected 3", tx_falls - falls0); end
      bus.send_start = 1'b0;
      tick(2);
   endtask
`endif

   initial begin
      total = 0;
      bad = 0;
      err_seen = 0;
      tx_falls = 0;
      tx_prev = 1'b1;
      reset = 1'b1;
      loopback = 1'b0;
      rx_drive = 1'b1;
      bus.send_connect = 1'b0;
      bus.send_start = 1'b0;
      bus.send_game_finish = 1'b0;
      bus.clear_rx = 1'b0;
      test_reset();
      test_single_start();
      test_absorb();
      test_loopback_connect();
      test_back_to_back();
      test_rx_frames();
      test_bad_parity();
      test_glitch();
      test_reset_mid_frame();
`ifdef LINK_ACK_EN
      test_link_fail();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
